// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        CARREGAR = 2'b00,   // idle / operand load
        SOMAR    = 2'b01,   // shift-add iterations
        PARA     = 2'b10    // product ready, one-cycle DONE
    } state_t;

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement magnitude: when i_signed is set and the
// operand is negative, return its negation; otherwise pass it through.
// The most-negative value maps to 2^(WIDTH-1), which is still exact when
// read back as an unsigned WIDTH-bit number.
module mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_magnitude
);

    assign o_magnitude = (i_signed && i_value[WIDTH-1]) ? -i_value : i_value;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier. One partial-product add per cycle,
// terminating early once no multiplier bits remain.
// Optional signed support is compiled in with macro SEQ_MULTIPLIER_SIGNED_EN:
// it adds the SIGNED_OP input, loads operand magnitudes and negates the
// result when the operand signs differ.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic               SIGNED_OP,
`endif
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] MULT_SAIDA
);

    state_t               r_state;
    state_t               w_state_next;

    logic [2*WIDTH-1:0]   r_pr;         // accumulated product
    logic [2*WIDTH-1:0]   r_br;         // shifted multiplicand
    logic [WIDTH-1:0]     r_ar;         // remaining multiplier bits
    logic [WIDTH-1:0]     w_ar_shift;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic                 r_neg;        // result sign for a signed operation

    mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_value     (A),
        .i_signed    (SIGNED_OP),
        .o_magnitude (w_a_mag)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_value     (B),
        .i_signed    (SIGNED_OP),
        .o_magnitude (w_b_mag)
    );
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
`endif

    assign w_ar_shift = r_ar >> 1;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= CARREGAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a zero multiplier skips straight to PARA; SOMAR
    // exits on the edge that consumes the last set multiplier bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CARREGAR: begin
                if (START) begin
                    w_state_next = (w_b_mag == '0) ? PARA : SOMAR;
                end
            end
            SOMAR: begin
                if (w_ar_shift == '0) begin
                    w_state_next = PARA;
                end
            end
            PARA:    w_state_next = CARREGAR;
            default: w_state_next = CARREGAR;
        endcase
    end

    // Datapath: load on an accepted START, shift-add while in SOMAR, hold otherwise.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pr <= '0;
            r_br <= '0;
            r_ar <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            r_neg <= 1'b0;
`endif
        end else begin
            case (r_state)
                CARREGAR: begin
                    if (START) begin
                        r_br <= {{WIDTH{1'b0}}, w_a_mag};
                        r_ar <= w_b_mag;
                        r_pr <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                        r_neg <= SIGNED_OP & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
                    end
                end
                SOMAR: begin
                    if (r_ar[0]) begin
                        r_pr <= r_pr + r_br;
                    end
                    r_br <= r_br << 1;
                    r_ar <= w_ar_shift;
                end
                default: begin
                end
            endcase
        end
    end

    assign DONE = (r_state == PARA);
    assign BUSY = (r_state != CARREGAR);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    assign MULT_SAIDA = r_neg ? -r_pr : r_pr;
`else
    assign MULT_SAIDA = r_pr;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8). A transaction-level
// model predicts BUSY/DONE/product each cycle; directed scenarios pin
// products and latencies with hand-computed literals.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b1;
    logic           START = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] MULT_SAIDA;
    logic           m_sop;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic           SIGNED_OP = 1'b0;
    assign m_sop = SIGNED_OP;
`else
    assign m_sop = 1'b0;
`endif

    always #5 CLK = ~CLK;

    seq_multiplier #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .SIGNED_OP  (SIGNED_OP),
`endif
        .A          (A),
        .B          (B),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .MULT_SAIDA (MULT_SAIDA)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    int             m_phase = P_IDLE;
    int             m_cnt   = 0;
    logic [2*W-1:0] m_out   = '0;
    logic [2*W-1:0] m_pend  = '0;

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                      input logic sop);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        if (sop) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
    endfunction

    // Number of clock edges after the accept edge until DONE is visible:
    // one per multiplier bit up to and including its MSB; zero for B==0
    // (DONE is already up in the first cycle after the accept edge).
    function automatic int model_latency(input logic [W-1:0] b, input logic sop);
        logic [W-1:0] mag;
        int lat;
        mag = (sop && b[W-1]) ? (~b + 8'd1) : b;
        lat = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lat = i + 1;
        end
        return lat;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_phase <= P_IDLE;
            m_cnt   <= 0;
            m_out   <= '0;
            m_pend  <= '0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (START) begin
                        if (model_latency(B, m_sop) == 0) begin
                            m_phase <= P_DONE;
                            m_out   <= model_product(A, B, m_sop);
                        end else begin
                            m_phase <= P_RUN;
                            m_cnt   <= model_latency(B, m_sop);
                            m_pend  <= model_product(A, B, m_sop);
                            m_out   <= '0;
                        end
                    end
                end
                P_RUN: begin
                    if (m_cnt == 1) begin
                        m_phase <= P_DONE;
                        m_out   <= m_pend;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Cycle compare against the model (product only when not mid-operation).
    bit cmp_en = 1'b0;
    always @(negedge CLK) begin
        if (cmp_en && RESET_N) begin
            check("model_busy", 64'(BUSY), 64'(m_phase != P_IDLE));
            check("model_done", 64'(DONE), 64'(m_phase == P_DONE));
            if (m_phase != P_RUN) check("model_product", 64'(MULT_SAIDA), 64'(m_out));
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input int exp_lat, input string tag);
        int n;
        @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(BUSY), 64'd1);
        n = 0;
        while (!DONE && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_product"}, 64'(MULT_SAIDA), 64'(exp_p));
        $display("op %s: A=%0d B=%0d product=0x%0h latency=%0d", tag, a, b, MULT_SAIDA, n);
        @(posedge CLK);
        #1;
        check({tag, "_busy_low_after"}, 64'(BUSY), 64'd0);
        check({tag, "_done_low_after"}, 64'(DONE), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        bit seen_done;

        // Asynchronous reset at power-up, before any clock edge.
        #2 RESET_N = 1'b0;
        #1;
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
        check("reset_product", 64'(MULT_SAIDA), 64'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        cmp_en = 1'b1;

        run_op(8'd13,  8'd11,  16'd143,   4, "13x11");
        run_op(8'd255, 8'd255, 16'd65025, 8, "255x255");
        run_op(8'd7,   8'd0,   16'd0,     0, "7x0");
        run_op(8'd1,   8'd1,   16'd1,     1, "1x1");

        // START re-pulsed during SOMAR with different operands: ignored.
        @(negedge CLK);
        A = 8'd200; B = 8'd128; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        @(posedge CLK); #1;
        A = 8'd1; B = 8'd1; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        n = 2;
        while (!DONE && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        check("repulse_latency", 64'(n), 64'd8);
        check("repulse_product", 64'(MULT_SAIDA), 64'd25600);
        $display("op repulse: 200x128 product=%0d latency=%0d", MULT_SAIDA, n);
        @(posedge CLK); #1;

        // START held high: accept, 2 SOMAR/PARA cycles, return, accept again.
        @(negedge CLK);
        A = 8'd3; B = 8'd2; START = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                pulses++;
                check("held_product", 64'(MULT_SAIDA), 64'd6);
                $display("op held: DONE at edge %0d product=%0d", i, MULT_SAIDA);
            end
        end
        START = 1'b0;
        check("held_pulses", 64'(pulses), 64'd3);
        repeat (2) @(posedge CLK);

        // Reset mid-operation: immediate clear, no DONE afterwards.
        @(negedge CLK);
        A = 8'd255; B = 8'd255; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("midreset_busy", 64'(BUSY), 64'd0);
        check("midreset_done", 64'(DONE), 64'd0);
        check("midreset_product", 64'(MULT_SAIDA), 64'd0);
        $display("op midreset: outputs busy=%0d done=%0d product=%0d", BUSY, DONE, MULT_SAIDA);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (DONE) seen_done = 1'b1;
        end
        check("midreset_no_done", 64'(seen_done), 64'd0);
        run_op(8'd5, 8'd5, 16'd25, 3, "5x5");

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        SIGNED_OP = 1'b1;
        run_op(8'hFD, 8'd5,  16'hFFF1, 3, "s_m3x5");
        run_op(8'h80, 8'h80, 16'd16384, 8, "s_m128xm128");
        run_op(8'd127, 8'hFF, 16'hFF81, 1, "s_127xm1");
        SIGNED_OP = 1'b0;
        run_op(8'hFD, 8'd5,  16'd1265, 3, "u_253x5");
`endif

        repeat (2) @(posedge CLK);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
